dht11_rx: RTL and testbench
===========================

# dht11_rx

Single-wire DHT11 sensor reader that sits directly upstream of the 5-byte UART frame sender. It issues the host start pulse, decodes the sensor's 40-bit reply, and verifies the checksum. On a valid frame it presents the 40-bit word on `Data` and pulses `Trans_go` for one cycle, which kicks the sender into transmitting the five bytes.

## Interface
Parameters:
- `CLK_MHZ`, 50: sys_clk frequency in MHz; sets the microsecond divider.
- `START_LOW_US`, 18000: duration the host drives the line low.
- `TIMEOUT_US`, 100: maximum wait in any sensor-driven phase.
- `BIT_THRESH_US`, 40: a high phase longer than this decodes as '1'.

Ports:
- `sys_clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle request to begin a read.
- `dht_in`  in  1  raw line level, asynchronous to sys_clk.
- `dht_oe`  out  1  1 = drive line low (open-drain), 0 = release.
- `Data`  out  40  last valid frame: [39:32] RH int, [31:24] RH dec, [23:16] T int, [15:8] T dec, [7:0] checksum.
- `Trans_go`  out  1  one-cycle pulse when `Data` is updated.
- `busy`  out  1  high in any state except IDLE.
- `err`  out  1  one-cycle pulse on timeout or checksum mismatch.

## Operation
- `dht_in` passes through a 2-flop synchronizer plus a 3rd history flop.
  - `fall` = sync3 & ~sync2; `rise` = ~sync3 & sync2.
- `us_tick` strobes once every `CLK_MHZ` cycles.
- `us_cnt` is 15 bits, cleared on every state change, incremented on `us_tick`, saturates at all-ones.
- FSM states:
  - IDLE: `dht_oe`=0. `start` → START_LOW.
  - START_LOW: `dht_oe`=1. When `us_cnt` == START_LOW_US → RELEASE.
  - RELEASE: `dht_oe`=0. `fall` → ACK_LOW.
  - ACK_LOW: `rise` → ACK_HIGH.
  - ACK_HIGH: `fall` → BIT_LOW; bit counter cleared to 0.
  - BIT_LOW: `rise` → BIT_HIGH.
  - BIT_HIGH: on `fall`, shift bit (`us_cnt` > BIT_THRESH_US) into the LSB of a 40-bit shift register, MSB first, and increment the bit counter. Counter == 39 at that `fall` → CHECK; otherwise → BIT_LOW.
  - CHECK (1 cycle):
    - If sr[7:0] == (sr[39:32]+sr[31:24]+sr[23:16]+sr[15:8]) mod 256: load `Data`, pulse `Trans_go`.
    - Otherwise: pulse `err`; `Data` is unchanged.
    - Then → IDLE.
- Timeout: in RELEASE, ACK_LOW, ACK_HIGH, BIT_LOW and BIT_HIGH, `us_cnt` == TIMEOUT_US → pulse `err`, → IDLE, `dht_oe`=0, `Data` unchanged.
- `start` is ignored when not in IDLE.
- `Trans_go` and `err` are never high in the same cycle.

## Timing
- Reset values: state IDLE, `dht_oe`=0, `Data`=40'h0, `Trans_go`=0, `busy`=0, `err`=0, shift register and counters 0.
- `dht_oe` rises on the clock edge after `start` is sampled, and stays high for START_LOW_US × CLK_MHZ cycles (±1 us).
- `Trans_go` and new `Data` are visible on the 4th sys_clk rising edge after the `dht_in` falling edge that ends bit 39:
  - 2 edges for the synchronizer;
  - 1 edge for the FSM to reach CHECK;
  - 1 edge for the registered output.
- `Data` is held stable between `Trans_go` pulses, so the downstream sender can read it for the whole transmission.
- Reset mid-frame: all registers return to reset values immediately, and `dht_oe` releases asynchronously.
- All outputs are registered.

## Structure
- Package `dht11_pkg` holds:
  - the state enum (IDLE, START_LOW, RELEASE, ACK_LOW, ACK_HIGH, BIT_LOW, BIT_HIGH, CHECK);
  - frame constants: FRAME_BITS=40, byte field offsets;
  - the default timing constants.
- Sub-module `us_tick_gen`, parameterized by CLK_MHZ, produces `us_tick`. It has its own counter and is reset by `rst_n`.
- Synchronizer, FSM, shift register and checksum logic live in `dht11_rx`.

## Test plan
- Sensor model replies with bytes 0x35,0x00,0x18,0x00,0x4D (highs of 27 us for '0', 70 us for '1') → `Data`=40'h350018004D, one `Trans_go` pulse 4 cycles after the final fall, `err` stays 0.
- Same frame with checksum 0x4E → one `err` pulse, no `Trans_go`, `Data` keeps its previous value.
- `dht_in` held high after START_LOW → `err` pulse 100 us after `dht_oe` falls, then IDLE, `busy`=0.
- Sensor stops mid-frame after bit 20 (line stuck high) → `err` after 100 us in BIT_HIGH; the next `start` yields a clean read of 40'h3C00190055.
- `start` pulsed during BIT_LOW → ignored; the frame completes normally, and there is exactly one START_LOW per accepted `start`.
- `rst_n` asserted for 3 cycles during START_LOW → `dht_oe`=0 immediately, `Data`=0, state IDLE; a subsequent `start` works normally.

Source files
------------

// File: rtl/dht11_pkg.sv
// Shared types and constants for the DHT11 single-wire reader.
package dht11_pkg;

    typedef enum logic [2:0] {
        IDLE, START_LOW, RELEASE, ACK_LOW, ACK_HIGH, BIT_LOW, BIT_HIGH, CHECK
    } dht_state_e;

    localparam int FRAME_BITS = 40;
    localparam int RH_INT_LSB = 32;
    localparam int RH_DEC_LSB = 24;
    localparam int T_INT_LSB  = 16;
    localparam int T_DEC_LSB  = 8;
    localparam int CSUM_LSB   = 0;

    localparam int US_CNT_W = 15;

    localparam int DEF_CLK_MHZ       = 50;
    localparam int DEF_START_LOW_US  = 18000;
    localparam int DEF_TIMEOUT_US    = 100;
    localparam int DEF_BIT_THRESH_US = 40;

    // Sensor checksum: low byte of the sum of the four data bytes.
    function automatic logic [7:0] frame_csum(input logic [FRAME_BITS-1:0] f);
        return f[RH_INT_LSB +: 8] + f[RH_DEC_LSB +: 8] + f[T_INT_LSB +: 8] + f[T_DEC_LSB +: 8];
    endfunction

endpackage

// File: rtl/dht11_rx_us_tick_gen.sv
// Microsecond strobe: one-cycle pulse every CLK_MHZ sys_clk cycles.
module us_tick_gen #(
    parameter int CLK_MHZ = 50
) (
    input  logic sys_clk,
    input  logic rst_n,
    output logic us_tick
);
    localparam int CW = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            us_tick <= 1'b0;
        end else if (cnt == CW'(CLK_MHZ - 1)) begin
            cnt     <= '0;
            us_tick <= 1'b1;
        end else begin
            cnt     <= cnt + 1'b1;
            us_tick <= 1'b0;
        end
    end

endmodule

// File: rtl/dht11_rx.sv
// DHT11 reader: host start pulse, 40-bit reply decode, checksum verify,
// and a one-cycle Trans_go handoff to the downstream frame sender.
module dht11_rx
    import dht11_pkg::*;
#(
    parameter int CLK_MHZ       = DEF_CLK_MHZ,
    parameter int START_LOW_US  = DEF_START_LOW_US,
    parameter int TIMEOUT_US    = DEF_TIMEOUT_US,
    parameter int BIT_THRESH_US = DEF_BIT_THRESH_US
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  dht_in,
    output logic                  dht_oe,
    output logic [FRAME_BITS-1:0] Data,
    output logic                  Trans_go,
    output logic                  busy,
    output logic                  err
);
    dht_state_e            state, state_nxt;
    logic                  sync1, sync2, sync3;
    logic                  fall, rise, us_tick, timeout, csum_ok;
    logic [US_CNT_W-1:0]   us_cnt;
    logic [5:0]            bit_cnt;
    logic [FRAME_BITS-1:0] sr;
    logic                  shift, clr_bits, load, tg_nxt, err_nxt;

    us_tick_gen #(.CLK_MHZ(CLK_MHZ)) u_tick (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .us_tick (us_tick)
    );

    // Synchronizer flops reset high to match the idle (pulled-up) line.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            sync3 <= 1'b1;
        end else begin
            sync1 <= dht_in;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign fall    = sync3 & ~sync2;
    assign rise    = ~sync3 & sync2;
    assign timeout = (us_cnt == US_CNT_W'(TIMEOUT_US));
    assign csum_ok = (sr[CSUM_LSB +: 8] == frame_csum(sr));

    always_comb begin
        state_nxt = state;
        shift     = 1'b0;
        clr_bits  = 1'b0;
        load      = 1'b0;
        tg_nxt    = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            IDLE:      if (start) state_nxt = START_LOW;
            START_LOW: if (us_cnt == US_CNT_W'(START_LOW_US)) state_nxt = RELEASE;
            RELEASE, ACK_LOW, ACK_HIGH, BIT_LOW, BIT_HIGH: begin
                if (timeout) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    case (state)
                        RELEASE:  if (fall) state_nxt = ACK_LOW;
                        ACK_LOW:  if (rise) state_nxt = ACK_HIGH;
                        ACK_HIGH: if (fall) begin
                            state_nxt = BIT_LOW;
                            clr_bits  = 1'b1;
                        end
                        BIT_LOW:  if (rise) state_nxt = BIT_HIGH;
                        default:  if (fall) begin
                            shift     = 1'b1;
                            state_nxt = (bit_cnt == 6'(FRAME_BITS - 1)) ? CHECK : BIT_LOW;
                        end
                    endcase
                end
            end
            CHECK: begin
                load      = csum_ok;
                tg_nxt    = csum_ok;
                err_nxt   = ~csum_ok;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            us_cnt   <= '0;
            bit_cnt  <= '0;
            sr       <= '0;
            Data     <= '0;
            Trans_go <= 1'b0;
            err      <= 1'b0;
            busy     <= 1'b0;
            dht_oe   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state)
                us_cnt <= '0;
            else if (us_tick && (us_cnt != '1))
                us_cnt <= us_cnt + 1'b1;
            if (clr_bits)
                bit_cnt <= '0;
            else if (shift)
                bit_cnt <= bit_cnt + 1'b1;
            // High-phase length decides the bit value, MSB arrives first.
            if (shift)
                sr <= {sr[FRAME_BITS-2:0], (us_cnt > US_CNT_W'(BIT_THRESH_US))};
            if (load)
                Data <= sr;
            Trans_go <= tg_nxt;
            err      <= err_nxt;
            busy     <= (state_nxt != IDLE);
            dht_oe   <= (state_nxt == START_LOW);
        end
    end

endmodule

// File: tb/tb_dht11_rx.sv
// Bench for dht11_rx: behavioural DHT11 sensor, table of read scenarios,
// reset abort sequence and randomized frames against a checksum model.
module tb_dht11_rx;
    localparam int CLK_MHZ  = 2;
    localparam int START_US = 200;
    localparam int TO_US    = 100;

    logic        sys_clk = 1'b0;
    logic        rst_n, start, drv;
    logic        dht_in, dht_oe, trans_go, busy, err;
    logic [39:0] data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int tg_cnt = 0, err_cnt = 0, both_cnt = 0, oe_rise_cnt = 0;
    int tg_cyc = 0, err_cyc = 0;
    logic oe_q = 1'b0;

    always #5 sys_clk = ~sys_clk;

    // Open-drain line with pull-up: host low wins, otherwise the sensor drives.
    assign dht_in = dht_oe ? 1'b0 : drv;

    dht11_rx #(
        .CLK_MHZ(CLK_MHZ), .START_LOW_US(START_US), .TIMEOUT_US(TO_US), .BIT_THRESH_US(40)
    ) dut (
        .sys_clk  (sys_clk),
        .rst_n    (rst_n),
        .start    (start),
        .dht_in   (dht_in),
        .dht_oe   (dht_oe),
        .Data     (data),
        .Trans_go (trans_go),
        .busy     (busy),
        .err      (err)
    );

    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(negedge sys_clk) begin
        if (trans_go) begin tg_cnt <= tg_cnt + 1; tg_cyc <= cyc; end
        if (err) begin err_cnt <= err_cnt + 1; err_cyc <= cyc; end
        if (trans_go && err) both_cnt <= both_cnt + 1;
        if (dht_oe && !oe_q) oe_rise_cnt <= oe_rise_cnt + 1;
        oe_q <= dht_oe;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_rng(input string nm, input int v, input int lo, input int hi);
        checks++;
        if (v < lo || v > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", nm, v, lo, hi);
        end
    endtask

    task automatic us(input int n);
        repeat (n * CLK_MHZ) @(negedge sys_clk);
    endtask

    task automatic pulse_start();
        @(negedge sys_clk) start = 1'b1;
        @(negedge sys_clk) start = 1'b0;
    endtask

    // mode 0: full reply; 1: no reply; 2: line stuck high after low phase of stop_bit.
    // start is pulsed again during the low phase of start_bit (if in range).
    task automatic do_read(input logic [39:0] frame, input int mode, input int stop_bit,
                           input int start_bit, output int fall_c, output int oe_len,
                           output int mark_c);
        int t0, lo, hi;
        fall_c = 0; oe_len = 0; mark_c = 0;
        pulse_start();
        for (int t = 0; t < 8 && !dht_oe; t++) @(negedge sys_clk);
        if (!dht_oe) begin
            chk("oe_rise_timeout", 0, 1);
            return;
        end
        t0 = cyc;
        for (int t = 0; t < (START_US + 10) * CLK_MHZ && dht_oe; t++) @(negedge sys_clk);
        if (dht_oe) begin
            chk("oe_fall_timeout", 1, 0);
            return;
        end
        oe_len = cyc - t0;
        mark_c = cyc;
        if (mode == 1) return;
        us(30);
        drv = 1'b0; us(80);
        drv = 1'b1; us(80);
        for (int i = 0; i < 40; i++) begin
            lo = int'($urandom_range(45, 55));
            hi = frame[39 - i] ? int'($urandom_range(62, 75)) : int'($urandom_range(22, 30));
            drv = 1'b0;
            if (i == start_bit) begin
                us(10);
                start = 1'b1;
                @(negedge sys_clk) start = 1'b0;
                us(lo - 11);
            end else begin
                us(lo);
            end
            drv = 1'b1;
            if (mode == 2 && i == stop_bit) begin
                mark_c = cyc;
                return;
            end
            us(hi);
        end
        drv = 1'b0;
        fall_c = cyc;
        us(50);
        drv = 1'b1;
    endtask

    task automatic check_read(input string nm, input logic [39:0] frame, input int mode,
                              input int stop_bit, input int start_bit, input logic exp_ok,
                              input logic [39:0] exp_data);
        int tg0, er0, oe0, fall_c, oe_len, mark_c;
        tg0 = tg_cnt; er0 = err_cnt; oe0 = oe_rise_cnt;
        do_read(frame, mode, stop_bit, start_bit, fall_c, oe_len, mark_c);
        us(130);
        chk({nm, "_trans_go_cnt"}, 64'(tg_cnt - tg0), exp_ok ? 64'd1 : 64'd0);
        chk({nm, "_err_cnt"}, 64'(err_cnt - er0), exp_ok ? 64'd0 : 64'd1);
        chk({nm, "_data"}, 64'(data), 64'(exp_data));
        chk({nm, "_busy"}, 64'(busy), 64'd0);
        chk({nm, "_start_lows"}, 64'(oe_rise_cnt - oe0), 64'd1);
        chk_rng({nm, "_oe_len"}, oe_len, (START_US - 1) * CLK_MHZ, (START_US + 1) * CLK_MHZ + 1);
        if (exp_ok) chk({nm, "_latency"}, 64'(tg_cyc - fall_c), 64'd4);
        if (mode != 0)
            chk_rng({nm, "_err_time"}, err_cyc - mark_c, (TO_US - 1) * CLK_MHZ,
                    (TO_US + 1) * CLK_MHZ + 5);
    endtask

    typedef struct {
        string       nm;
        logic [39:0] frame;
        int          mode;
        int          stop_bit;
        int          start_bit;
        logic        exp_ok;
        logic [39:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [39:0] model_data, frame;
        logic [7:0]  b[4];
        int          sum;
        logic        ok;

        vecs[0] = '{"good",     40'h350018004D, 0, -1, -1, 1'b1, 40'h350018004D};
        vecs[1] = '{"bad_csum", 40'h350018004E, 0, -1, -1, 1'b0, 40'h350018004D};
        vecs[2] = '{"no_reply", 40'h0,          1, -1, -1, 1'b0, 40'h350018004D};
        vecs[3] = '{"stuck_b20",40'h3C00190055, 2, 20, -1, 1'b0, 40'h350018004D};
        vecs[4] = '{"recover",  40'h3C00190055, 0, -1, -1, 1'b1, 40'h3C00190055};
        vecs[5] = '{"start_ign",40'h2A01170547, 0, -1, 10, 1'b1, 40'h2A01170547};

        rst_n = 1'b0; start = 1'b0; drv = 1'b1;
        repeat (3) @(negedge sys_clk);
        chk("rst_oe", 64'(dht_oe), 64'd0);
        chk("rst_data", 64'(data), 64'd0);
        chk("rst_trans_go", 64'(trans_go), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        for (int i = 0; i < 6; i++)
            check_read(vecs[i].nm, vecs[i].frame, vecs[i].mode, vecs[i].stop_bit,
                       vecs[i].start_bit, vecs[i].exp_ok, vecs[i].exp_data);

        // Reset in the middle of the host start pulse.
        pulse_start();
        us(50);
        chk("pre_rst_busy", 64'(busy), 64'd1);
        chk("pre_rst_oe", 64'(dht_oe), 64'd1);
        @(negedge sys_clk) rst_n = 1'b0;
        #1;
        chk("mid_rst_oe", 64'(dht_oe), 64'd0);
        chk("mid_rst_data", 64'(data), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        repeat (3) @(negedge sys_clk);
        rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);
        model_data = 40'h350018004D;
        check_read("post_rst", 40'h350018004D, 0, -1, -1, 1'b1, model_data);

        // Random frames: model keeps the last frame whose checksum holds.
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) b[k] = 8'($urandom);
            sum = (int'(b[0]) + int'(b[1]) + int'(b[2]) + int'(b[3])) % 256;
            if ($urandom_range(0, 2) == 0) sum = (sum + 1 + int'($urandom_range(0, 250))) % 256;
            frame = {b[0], b[1], b[2], b[3], 8'(sum)};
            ok = ((int'(b[0]) + int'(b[1]) + int'(b[2]) + int'(b[3])) % 256) == sum;
            if (ok) model_data = frame;
            check_read($sformatf("rand%0d", r), frame, 0, -1, -1, ok, model_data);
        end

        chk("no_overlap", 64'(both_cnt), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
